// File: rtl/ifetch_prefetch.sv
// Instruction prefetch: issues in-order memory reads into a small queue and flushes on redirect.
// Optional build macro IFETCH_ALIGN_CHK_EN reports misaligned redirect targets on op_misalign.
module ifetch_prefetch #(
  parameter int PC_W     = 10,
  parameter int DATA_W   = 32,
  parameter int Q_DEPTH  = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ip_redirect,
  input  logic [PC_W-1:0]   ip_redirect_pc,
  input  logic              ip_stall,
  output logic              op_imem_req,
  output logic [PC_W-1:0]   op_imem_addr,
  input  logic              ip_imem_ack,
  input  logic              ip_imem_rvalid,
  input  logic [DATA_W-1:0] ip_imem_rdata,
  output logic              op_valid,
  output logic [DATA_W-1:0] op_instruction,
  output logic [PC_W-1:0]   op_PC,
  output logic [PC_W-1:0]   op_PC_plus_4,
  output logic              op_misalign
);

  localparam int AW = $clog2(Q_DEPTH);
  localparam int CW = $clog2(Q_DEPTH) + 1;
  localparam logic [CW:0]     LP_DEPTH      = (CW+1)'(Q_DEPTH);
  localparam logic [PC_W-1:0] LP_FOUR       = PC_W'(4);
  localparam logic [PC_W-1:0] LP_ALIGN_MASK = ~PC_W'(3);
  localparam logic [PC_W-1:0] LP_RESET_PC   = PC_W'(RESET_PC) & LP_ALIGN_MASK;

  logic [DATA_W-1:0] r_q_instr [Q_DEPTH];
  logic [PC_W-1:0]   r_q_pc    [Q_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_outstanding;
  logic [CW-1:0]     r_discard_cnt;
  logic [PC_W-1:0]   r_fetch_pc;
  logic [PC_W-1:0]   r_resp_pc;

  logic              w_req;
  logic              w_accept;
  logic              w_resp;
  logic              w_push;
  logic              w_pop;
  logic [CW:0]       w_budget;
  logic [CW-1:0]     w_outstanding_nxt;
  logic [PC_W-1:0]   w_redirect_pc;

  // Outstanding includes requests whose responses will be discarded, so the
  // queue always has room for every response still in flight.
  always_comb begin
    w_budget          = {1'b0, r_count} + {1'b0, r_outstanding};
    w_req             = !reset && !ip_redirect && (w_budget < LP_DEPTH);
    w_accept          = w_req && ip_imem_ack;
    w_resp            = ip_imem_rvalid && (r_outstanding != '0);
    w_push            = w_resp && !ip_redirect && (r_discard_cnt == '0);
    w_pop             = op_valid && !ip_stall && !ip_redirect;
    w_outstanding_nxt = r_outstanding + CW'(w_accept) - CW'(w_resp);
    w_redirect_pc     = ip_redirect_pc & LP_ALIGN_MASK;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_pc    <= LP_RESET_PC;
      r_resp_pc     <= LP_RESET_PC;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard_cnt <= '0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      if (ip_redirect) begin
        // A response arriving this cycle is already dropped and excluded.
        r_fetch_pc    <= w_redirect_pc;
        r_resp_pc     <= w_redirect_pc;
        r_discard_cnt <= w_outstanding_nxt;
        r_wr_ptr      <= '0;
        r_rd_ptr      <= '0;
        r_count       <= '0;
      end else begin
        if (w_accept) begin
          r_fetch_pc <= r_fetch_pc + LP_FOUR;
        end
        if (w_resp && (r_discard_cnt != '0)) begin
          r_discard_cnt <= r_discard_cnt - 1'b1;
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + LP_FOUR;
          r_wr_ptr  <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= ip_imem_rdata;
      r_q_pc[r_wr_ptr]    <= r_resp_pc;
    end
  end

  assign op_imem_req    = w_req;
  assign op_imem_addr   = r_fetch_pc;
  assign op_valid       = (r_count != '0);
  assign op_instruction = op_valid ? r_q_instr[r_rd_ptr] : '0;
  assign op_PC          = op_valid ? r_q_pc[r_rd_ptr] : '0;
  assign op_PC_plus_4   = op_PC + LP_FOUR;

`ifdef IFETCH_ALIGN_CHK_EN
  logic r_misalign;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else if (ip_redirect && (ip_redirect_pc[1:0] != 2'b00)) begin
      r_misalign <= 1'b1;
    end
  end

  assign op_misalign = r_misalign;
`else
  assign op_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Scoreboard bench for ifetch_prefetch: random memory/stall/redirect stimulus, expected
// in-order PC stream rebuilt from each redirect target, checked by a decoupled monitor.
module tb_ifetch_prefetch;

  localparam int PC_W    = 10;
  localparam int DATA_W  = 32;
  localparam int Q_DEPTH = 4;
  localparam int PC_MOD  = 1 << PC_W;
`ifdef IFETCH_ALIGN_CHK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              ip_redirect;
  logic [PC_W-1:0]   ip_redirect_pc;
  logic              ip_stall;
  logic              op_imem_req;
  logic [PC_W-1:0]   op_imem_addr;
  logic              ip_imem_ack;
  logic              ip_imem_rvalid;
  logic [DATA_W-1:0] ip_imem_rdata;
  logic              op_valid;
  logic [DATA_W-1:0] op_instruction;
  logic [PC_W-1:0]   op_PC;
  logic [PC_W-1:0]   op_PC_plus_4;
  logic              op_misalign;

  ifetch_prefetch #(
    .PC_W    (PC_W),
    .DATA_W  (DATA_W),
    .Q_DEPTH (Q_DEPTH),
    .RESET_PC(0)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ip_redirect    (ip_redirect),
    .ip_redirect_pc (ip_redirect_pc),
    .ip_stall       (ip_stall),
    .op_imem_req    (op_imem_req),
    .op_imem_addr   (op_imem_addr),
    .ip_imem_ack    (ip_imem_ack),
    .ip_imem_rvalid (ip_imem_rvalid),
    .ip_imem_rdata  (ip_imem_rdata),
    .op_valid       (op_valid),
    .op_instruction (op_instruction),
    .op_PC          (op_PC),
    .op_PC_plus_4   (op_PC_plus_4),
    .op_misalign    (op_misalign)
  );

  always #5 clock = ~clock;

  typedef struct {
    int addr;
    int ready;
  } mem_req_t;

  int n_cmp = 0;
  int n_err = 0;
  int cycle = 0;
  int n_consumed = 0;
  int first_valid = -1;
  int lat_min = 1, lat_max = 1, ack_pct = 100, gap_pct = 0;

  mem_req_t pend[$];
  int       exp_q[$];
  int       next_exp = 0;
  bit       exp_mis = 1'b0;
  bit       prev_redirect = 1'b0;
  bit       prev_req_wait = 1'b0;
  logic [PC_W-1:0] prev_addr = '0;

  always @(posedge clock) cycle <= cycle + 1;

  function automatic logic [DATA_W-1:0] mem_word(input int a);
    logic [31:0] x;
    x = 32'(a) * 32'h9E37_79B9;
    return x ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Memory model: random ack, in-order responses after a random latency, random gaps.
  task automatic drive_mem();
    ip_imem_ack = ($urandom_range(99) < ack_pct);
    if (!reset && pend.size() > 0 && pend[0].ready <= cycle && $urandom_range(99) >= gap_pct) begin
      ip_imem_rvalid = 1'b1;
      ip_imem_rdata  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      ip_imem_rvalid = 1'b0;
      ip_imem_rdata  = $urandom;
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    ip_redirect = 1'b0;
    drive_mem();
  endtask

  task automatic redirect(input int target);
    ip_redirect    = 1'b1;
    ip_redirect_pc = PC_W'(target);
    exp_q.delete();
    next_exp = target & (PC_MOD - 4);
  endtask

  // Monitor: compares the presented head entry with the expected stream.
  always @(negedge clock) begin
    if (reset) begin
      pend.delete();
      exp_mis       = 1'b0;
      prev_redirect = 1'b0;
      prev_req_wait = 1'b0;
      first_valid   = -1;
    end else begin
      while (exp_q.size() < 4) begin
        exp_q.push_back(next_exp);
        next_exp = (next_exp + 4) % PC_MOD;
      end
      if (prev_redirect) check("flush_valid", op_valid, 0);
      if (ip_redirect) check("req_low_on_redirect", op_imem_req, 0);
      check("addr_aligned", op_imem_addr[1:0], 0);
      if (prev_req_wait && !ip_redirect) begin
        check("req_hold", op_imem_req, 1);
        check("addr_hold", op_imem_addr, prev_addr);
      end
      if (op_imem_req && ip_imem_ack) begin
        pend.push_back('{int'(op_imem_addr), cycle + int'($urandom_range(lat_max, lat_min))});
        check("inflight_bound", pend.size() <= Q_DEPTH, 1);
      end
      if (op_valid && first_valid < 0) first_valid = cycle;
      if (op_valid && !ip_redirect) begin
        check("pc", op_PC, exp_q[0]);
        check("pc_plus_4", op_PC_plus_4, (exp_q[0] + 4) % PC_MOD);
        check("instruction", op_instruction, mem_word(exp_q[0]));
        if (!ip_stall) begin
          void'(exp_q.pop_front());
          n_consumed++;
        end
      end
      check("misalign", op_misalign, exp_mis);
      if (MIS_EN && ip_redirect && ip_redirect_pc[1:0] != 2'b00) exp_mis = 1'b1;
      prev_redirect = ip_redirect;
      prev_req_wait = op_imem_req && !ip_imem_ack;
      prev_addr     = op_imem_addr;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int rel_cycle;
    int c0;
    reset          = 1'b1;
    ip_redirect    = 1'b0;
    ip_redirect_pc = '0;
    ip_stall       = 1'b0;
    ip_imem_ack    = 1'b0;
    ip_imem_rvalid = 1'b0;
    ip_imem_rdata  = '0;

    repeat (3) step();
    check("rst_valid", op_valid, 0);
    check("rst_req", op_imem_req, 0);
    check("rst_misalign", op_misalign, 0);
    check("rst_instruction", op_instruction, 0);
    check("rst_pc", op_PC, 0);
    check("rst_pc_plus_4", op_PC_plus_4, 4);

    // Latency 1, always ack, no stall: stream 0,4,8,... and op_valid in the third cycle.
    step();
    reset     = 1'b0;
    rel_cycle = cycle;
    repeat (20) step();
    check("first_valid_cycle", first_valid - rel_cycle, 2);
    check("progress_basic", n_consumed >= 15, 1);

    // Hold the consumer off long enough to fill the queue.
    for (int i = 0; i < 5; i++) begin
      step();
      ip_stall = 1'b1;
    end
    #1;
    check("req_off_when_full", op_imem_req, 0);
    step();
    ip_stall = 1'b0;
    repeat (10) step();

    // Redirect with several requests in flight at latency 3.
    lat_min = 3;
    lat_max = 3;
    repeat (10) step();
    step();
    redirect(32'h40);
    c0 = n_consumed;
    repeat (20) step();
    check("progress_redirect", n_consumed - c0 >= 4, 1);

    // Address wrap at the top of the PC space.
    lat_min = 1;
    lat_max = 1;
    step();
    redirect(32'h3F8);
    c0 = n_consumed;
    repeat (12) step();
    check("progress_wrap", n_consumed - c0 >= 4, 1);

    // Misaligned redirect target.
    step();
    redirect(32'h42);
    step();
    check("misalign_direct", op_misalign, MIS_EN);
    c0 = n_consumed;
    repeat (10) step();
    check("progress_misalign", n_consumed - c0 >= 4, 1);

    // Reset in the middle of traffic; the memory is reset alongside.
    lat_max = 3;
    step();
    reset    = 1'b1;
    ip_stall = 1'b0;
    exp_q.delete();
    next_exp = 0;
    step();
    step();
    reset = 1'b0;
    c0 = n_consumed;
    repeat (15) step();
    check("progress_after_reset", n_consumed - c0 >= 4, 1);

    // Random traffic: ack/rvalid gaps, stalls, redirects (sometimes during a stall).
    lat_min = 1;
    lat_max = 4;
    ack_pct = 70;
    gap_pct = 30;
    c0 = n_consumed;
    for (int i = 0; i < 10000; i++) begin
      step();
      ip_stall = ($urandom_range(3) == 0);
      if ($urandom_range(59) == 0) redirect(int'($urandom_range(PC_MOD - 1)));
    end
    step();
    check("progress_random", n_consumed - c0 > 1000, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
